store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 15 +
 rtl/store_buffer_fwd_merge.sv | 27 ++
 rtl/store_buffer.sv | 119 +++++++++++
 tb/tb_store_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared memory-subsystem constants and the store-buffer entry layout.
package store_buffer_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int WORD_ADDR_W      = 30;
    localparam int DATA_W           = 32;
    localparam int BE_W             = DATA_W / 8;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] word;
        logic [DATA_W-1:0]      data;
        logic [BE_W-1:0]        be;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd_merge.sv
// Per-lane store-to-load forwarding: the youngest matching entry wins each
// byte lane; lanes with no match fall through to the memory read word.
module sb_fwd_merge
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  sb_entry_t [DEPTH-1:0]  entries,   // index 0 = oldest
    input  logic [DEPTH-1:0]       valid,
    input  logic [WORD_ADDR_W-1:0] ld_word,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [DATA_W-1:0]      ld_rdata
);

    // Walk oldest to youngest so later (younger) matches overwrite earlier ones.
    always_comb begin
        ld_rdata = mem_rdata;
        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < BE_W; i++) begin
                if (valid[k] && (entries[k].word == ld_word) && entries[k].be[i]) begin
                    ld_rdata[8*i +: 8] = entries[k].data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: FIFO of pending stores that drain to data memory whenever
// the load path does not need the memory port, with load forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_byte_enable,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    output logic [31:0] ld_rdata,
    output logic        sb_empty,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    sb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  full;
    logic                  enq;
    logic                  drain;
    sb_entry_t [DEPTH-1:0] ordered;
    logic [DEPTH-1:0]      ordered_valid;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign full     = (count_q == FULL_CNT);
    assign st_ready = !full;
    assign ld_ready = ld_valid && !full;
    assign sb_empty = (count_q == '0);
    // A zero-enable store completes the handshake but never occupies an entry.
    assign enq      = st_valid && !full && (st_byte_enable != '0);
    assign drain    = !ld_ready && (count_q != '0);

    // Memory port: load wins unless the buffer is full, then the head drains.
    always_comb begin
        mem_addr        = {ld_addr[31:2], 2'b00};
        mem_wdata       = entries_q[head_q].data;
        mem_byte_enable = '0;
        if (!ld_ready && drain) begin
            mem_addr        = {entries_q[head_q].word, 2'b00};
            mem_byte_enable = entries_q[head_q].be;
        end
    end

    // FIFO next state: enqueue at tail, drain at head, count tracks occupancy.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (enq) begin
            entries_d[tail_q] = '{word: st_addr[31:2], data: st_wdata, be: st_byte_enable};
            tail_d            = tail_q + PTR_W'(1);
        end
        if (drain) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({enq, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Present registered entries oldest-first; the entry draining now is still valid.
    always_comb begin
        ordered       = '0;
        ordered_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ordered[k]       = entries_q[head_q + PTR_W'(k)];
            ordered_valid[k] = (CNT_W'(k) < count_q);
        end
    end

    sb_fwd_merge #(.DEPTH(DEPTH)) u_fwd_merge (
        .entries   (ordered),
        .valid     (ordered_valid),
        .ld_word   (ld_addr[31:2]),
        .mem_rdata (mem_rdata),
        .ld_rdata  (ld_rdata)
    );

    // Pointer and occupancy state; reset discards every buffered store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is unreset; validity comes only from head/count.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_byte_enable;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_rdata;
    logic        sb_empty;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic        st_v;
        logic [31:0] st_a;
        logic [31:0] st_d;
        logic [3:0]  st_be;
        logic        ld_v;
        logic [31:0] ld_a;
        logic [31:0] mrd;
        logic        e_st_rdy;
        logic        e_ld_rdy;
        logic        e_empty;
        logic [3:0]  e_mbe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwd;
        logic [31:0] e_lrd;
    } vec_t;

    vec_t vecs[$];
    logic [63:0] wlog[$];

    store_buffer #(.DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .st_valid        (st_valid),
        .st_ready        (st_ready),
        .st_addr         (st_addr),
        .st_wdata        (st_wdata),
        .st_byte_enable  (st_byte_enable),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_addr         (ld_addr),
        .ld_rdata        (ld_rdata),
        .sb_empty        (sb_empty),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory write log, sampled just before each rising edge.
    always @(negedge clk) begin
        #4;
        if (mem_byte_enable != 4'h0) wlog.push_back({mem_addr, mem_wdata});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic add_vec(input logic st_v, input logic [31:0] st_a, input logic [31:0] st_d,
                           input logic [3:0] st_be, input logic ld_v, input logic [31:0] ld_a,
                           input logic [31:0] mrd, input logic e_st_rdy, input logic e_ld_rdy,
                           input logic e_empty, input logic [3:0] e_mbe, input logic [31:0] e_maddr,
                           input logic [31:0] e_mwd, input logic [31:0] e_lrd);
        vec_t v;
        v = '{st_v, st_a, st_d, st_be, ld_v, ld_a, mrd, e_st_rdy, e_ld_rdy, e_empty,
              e_mbe, e_maddr, e_mwd, e_lrd};
        vecs.push_back(v);
    endtask

    task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = v; st_addr = a; st_wdata = d; st_byte_enable = be;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_st(1'b0, 32'h0, 32'h0, 4'h0);
        ld_valid = 1'b1; ld_addr = 32'h0; mem_rdata = 32'h0;

        //      st_v  st_a       st_d          be    ld_v  ld_a       mrd           srdy lrdy empty mbe   maddr      mwd           lrd
        add_vec(1'b0, 32'h0,     32'h0,        4'h0, 1'b0, 32'h0,     32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 4'h0, 32'h0,     32'h0,        32'hDEADBEEF);
        add_vec(1'b1, 32'h100,   32'h11223344, 4'hF, 1'b0, 32'h100,   32'h0,        1'b1, 1'b0, 1'b1, 4'h0, 32'h0,     32'h0,        32'h0);
        add_vec(1'b0, 32'h0,     32'h0,        4'h0, 1'b1, 32'h100,   32'h0,        1'b1, 1'b1, 1'b0, 4'h0, 32'h100,   32'h0,        32'h11223344);
        add_vec(1'b0, 32'h0,     32'h0,        4'h0, 1'b0, 32'h100,   32'h0,        1'b1, 1'b0, 1'b0, 4'hF, 32'h100,   32'h11223344, 32'h11223344);
        add_vec(1'b0, 32'h0,     32'h0,        4'h0, 1'b0, 32'h100,   32'h0,        1'b1, 1'b0, 1'b1, 4'h0, 32'h0,     32'h0,        32'h0);
        add_vec(1'b1, 32'h200,   32'h000000AA, 4'h1, 1'b1, 32'h202,   32'h55667788, 1'b1, 1'b1, 1'b1, 4'h0, 32'h200,   32'h0,        32'h55667788);
        add_vec(1'b1, 32'h201,   32'h0000BB00, 4'h2, 1'b1, 32'h200,   32'h55667788, 1'b1, 1'b1, 1'b0, 4'h0, 32'h200,   32'h0,        32'h556677AA);
        add_vec(1'b0, 32'h0,     32'h0,        4'h0, 1'b1, 32'h200,   32'h55667788, 1'b1, 1'b1, 1'b0, 4'h0, 32'h200,   32'h0,        32'h5566BBAA);
        add_vec(1'b0, 32'h0,     32'h0,        4'h0, 1'b0, 32'h200,   32'h55667788, 1'b1, 1'b0, 1'b0, 4'h1, 32'h200,   32'h000000AA, 32'h5566BBAA);
        add_vec(1'b0, 32'h0,     32'h0,        4'h0, 1'b0, 32'h200,   32'h55667788, 1'b1, 1'b0, 1'b0, 4'h2, 32'h200,   32'h0000BB00, 32'h5566BB88);
        add_vec(1'b0, 32'h0,     32'h0,        4'h0, 1'b0, 32'h200,   32'h55667788, 1'b1, 1'b0, 1'b1, 4'h0, 32'h0,     32'h0,        32'h55667788);
        add_vec(1'b1, 32'h400,   32'hFFFFFFFF, 4'h0, 1'b0, 32'h400,   32'h01020304, 1'b1, 1'b0, 1'b1, 4'h0, 32'h0,     32'h0,        32'h01020304);
        add_vec(1'b0, 32'h0,     32'h0,        4'h0, 1'b0, 32'h400,   32'h01020304, 1'b1, 1'b0, 1'b1, 4'h0, 32'h0,     32'h0,        32'h01020304);

        // Outputs while reset is held.
        #2;
        chk("rst_st_ready", 32'(st_ready), 32'h1);
        chk("rst_sb_empty", 32'(sb_empty), 32'h1);
        chk("rst_ld_ready_hi", 32'(ld_ready), 32'h1);
        chk("rst_mem_be", 32'(mem_byte_enable), 32'h0);
        ld_valid = 1'b0;
        #1;
        chk("rst_ld_ready_lo", 32'(ld_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            @(negedge clk);
            drive_st(vecs[n].st_v, vecs[n].st_a, vecs[n].st_d, vecs[n].st_be);
            ld_valid = vecs[n].ld_v; ld_addr = vecs[n].ld_a; mem_rdata = vecs[n].mrd;
            #1;
            chk($sformatf("v%0d_st_ready", n), 32'(st_ready), 32'(vecs[n].e_st_rdy));
            chk($sformatf("v%0d_ld_ready", n), 32'(ld_ready), 32'(vecs[n].e_ld_rdy));
            chk($sformatf("v%0d_sb_empty", n), 32'(sb_empty), 32'(vecs[n].e_empty));
            chk($sformatf("v%0d_mem_be", n), 32'(mem_byte_enable), 32'(vecs[n].e_mbe));
            chk($sformatf("v%0d_ld_rdata", n), ld_rdata, vecs[n].e_lrd);
            if (vecs[n].e_mbe != 4'h0 || vecs[n].e_ld_rdy)
                chk($sformatf("v%0d_mem_addr", n), mem_addr, vecs[n].e_maddr);
            if (vecs[n].e_mbe != 4'h0)
                chk($sformatf("v%0d_mem_wdata", n), mem_wdata, vecs[n].e_mwd);
        end

        // Fill with loads pending, then full: drain beats load, new store stalls.
        wlog.delete();
        ld_valid = 1'b1; ld_addr = 32'h500; mem_rdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_st(1'b1, 32'h10 + 32'(4*k), 32'(k+1), 4'hF);
            #1;
            chk($sformatf("fill%0d_st_ready", k), 32'(st_ready), 32'h1);
            chk($sformatf("fill%0d_ld_ready", k), 32'(ld_ready), 32'h1);
        end
        @(negedge clk);
        drive_st(1'b1, 32'h20, 32'h55, 4'hF);
        #1;
        chk("full_st_ready", 32'(st_ready), 32'h0);
        chk("full_ld_ready", 32'(ld_ready), 32'h0);
        chk("full_mem_be", 32'(mem_byte_enable), 32'hF);
        chk("full_mem_addr", mem_addr, 32'h10);
        chk("full_mem_wdata", mem_wdata, 32'h1);
        @(negedge clk);
        #1;
        chk("after_drain_st_ready", 32'(st_ready), 32'h1);
        chk("after_drain_ld_ready", 32'(ld_ready), 32'h1);
        chk("after_drain_mem_be", 32'(mem_byte_enable), 32'h0);
        @(negedge clk);
        drive_st(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("refull_st_ready", 32'(st_ready), 32'h0);
        chk("refull_mem_addr", mem_addr, 32'h14);
        ld_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("fill_drained_empty", 32'(sb_empty), 32'h1);
        chk("fill_write_count", 32'(wlog.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < wlog.size()) begin
                chk($sformatf("fill_w%0d_addr", k), wlog[k][63:32], (k < 4) ? 32'h10 + 32'(4*k) : 32'h20);
                chk($sformatf("fill_w%0d_data", k), wlog[k][31:0], (k < 4) ? 32'(k+1) : 32'h55);
            end
        end

        // Program-order drain with simultaneous enqueue and drain.
        wlog.delete();
        @(negedge clk);
        drive_st(1'b1, 32'h300, 32'hA0A0A0A0, 4'hF);
        #1;
        chk("ord_first_mem_be", 32'(mem_byte_enable), 32'h0);
        @(negedge clk);
        drive_st(1'b1, 32'h304, 32'hB1B1B1B1, 4'hF);
        #1;
        chk("ord_drain0_addr", mem_addr, 32'h300);
        chk("ord_drain0_be", 32'(mem_byte_enable), 32'hF);
        @(negedge clk);
        drive_st(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("ord_drain1_addr", mem_addr, 32'h304);
        chk("ord_mid_empty", 32'(sb_empty), 32'h0);
        @(negedge clk);
        #1;
        chk("ord_sb_empty", 32'(sb_empty), 32'h1);
        chk("ord_write_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("ord_w0_addr", wlog[0][63:32], 32'h300);
            chk("ord_w1_addr", wlog[1][63:32], 32'h304);
        end

        // Reset with three entries buffered and a drain in progress.
        wlog.delete();
        ld_valid = 1'b1; ld_addr = 32'h600;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_st(1'b1, 32'h700 + 32'(4*k), 32'hC0 + 32'(k), 4'hF);
        end
        @(negedge clk);
        drive_st(1'b0, 32'h0, 32'h0, 4'h0);
        ld_valid = 1'b0;
        #1;
        chk("prerst_mem_be", 32'(mem_byte_enable), 32'hF);
        chk("prerst_sb_empty", 32'(sb_empty), 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_sb_empty", 32'(sb_empty), 32'h1);
        chk("midrst_mem_be", 32'(mem_byte_enable), 32'h0);
        chk("midrst_st_ready", 32'(st_ready), 32'h1);
        ld_valid = 1'b1;
        #1;
        chk("midrst_ld_ready", 32'(ld_ready), 32'h1);
        ld_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("postrst_write_count", 32'(wlog.size()), 32'd0);
        chk("postrst_sb_empty", 32'(sb_empty), 32'h1);
        chk("postrst_mem_be", 32'(mem_byte_enable), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
